// File: rtl/shift_reg_sequencer.sv
// Sequences load/shift/clear strobes for a parallel-load shift register, one word at a time.
// Optional macro SHIFT_SEQ_BACK2BACK_EN lets a new word be accepted during the DONE cycle.
module shift_reg_sequencer #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        FILL_BIT = 1'b0
) (
  input  logic                       clock,
  input  logic                       sclr,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       abort,
  output logic                       sr_load,
  output logic                       sr_enable,
  output logic [WIDTH-1:0]           sr_data,
  output logic                       sr_shiftin,
  output logic                       sr_sclr,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(WIDTH);

  typedef enum logic [2:0] {StIdle, StLoad, StShift, StDone, StFlush} state_e;

  state_e state_q, state_d;
  logic   ready_q;
  logic   hs;

  // Reset must block the handshake even though ready_q is already set by then.
  assign in_ready   = ready_q & ~sclr;
  assign hs         = in_valid & in_ready;
  assign sr_shiftin = FILL_BIT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StLoad;
      StLoad:  state_d = abort ? StFlush : StShift;
      StShift: begin
        if (abort)                  state_d = StFlush;
        else if (bit_cnt == LastCnt) state_d = StDone;
      end
`ifdef SHIFT_SEQ_BACK2BACK_EN
      StDone:  state_d = hs ? StLoad : StIdle;
`else
      StDone:  state_d = StIdle;
`endif
      StFlush: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q   <= StIdle;
      ready_q   <= 1'b1;
      sr_data   <= '0;
      bit_cnt   <= '0;
      sr_load   <= 1'b0;
      sr_enable <= 1'b0;
      sr_sclr   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) sr_data <= in_data;
      case (state_d)
        StShift: bit_cnt <= (state_q == StShift) ? bit_cnt + CntW'(1) : '0;
        StDone:  bit_cnt <= FullCnt;
        default: bit_cnt <= '0;
      endcase
`ifdef SHIFT_SEQ_BACK2BACK_EN
      ready_q   <= (state_d == StIdle) || (state_d == StDone);
`else
      ready_q   <= (state_d == StIdle);
`endif
      sr_load   <= (state_d == StLoad);
      sr_enable <= (state_d == StLoad) || (state_d == StShift) || (state_d == StFlush);
      sr_sclr   <= (state_d == StFlush);
      busy      <= (state_d == StLoad) || (state_d == StShift) || (state_d == StFlush);
      done      <= (state_d == StDone);
    end
  end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Self-checking bench for shift_reg_sequencer (WIDTH=8) against a frame-timeline model.
module tb_shift_reg_sequencer;

  localparam int W = 8;
`ifdef SHIFT_SEQ_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       sclr = 1'b1, in_valid = 1'b0, abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, sr_load, sr_enable, sr_shiftin, sr_sclr, busy, done;
  logic [7:0] sr_data;
  logic [3:0] bit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  shift_reg_sequencer #(.WIDTH(W), .FILL_BIT(1'b0)) dut (
    .clock(clock), .sclr(sclr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .abort(abort), .sr_load(sr_load), .sr_enable(sr_enable),
    .sr_data(sr_data), .sr_shiftin(sr_shiftin), .sr_sclr(sr_sclr), .busy(busy),
    .done(done), .bit_cnt(bit_cnt)
  );

  always #5 clock = ~clock;

  // Model: phase 0 idle, 1 in a frame (t = edges since handshake), 2 flush.
  int         m_phase = 0;
  int         m_t     = 0;
  logic [7:0] m_word  = 8'h00;
  int         cyc     = 0;

  always @(posedge clock) begin : model
    bit rdy;
    rdy = ((m_phase == 0) || (B2B && m_phase == 1 && m_t == W + 2)) && !sclr;
    cyc++;
    if (sclr) begin
      m_phase = 0;
      m_word  = 8'h00;
    end else if (m_phase == 1 && m_t >= 1 && m_t <= W + 1 && abort) begin
      m_phase = 2;
    end else if (in_valid && rdy) begin
      m_phase = 1;
      m_t     = 1;
      m_word  = in_data;
    end else if (m_phase == 1) begin
      m_t++;
      if (m_t == W + 3) m_phase = 0;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
  end

  logic [18:0] expv, obs;
  always_comb begin
    logic fr, e_ready, e_load, e_en, e_sclr, e_busy, e_done;
    logic [3:0] e_cnt;
    fr      = (m_phase == 1);
    e_ready = ((m_phase == 0) || (B2B && fr && m_t == W + 2)) && !sclr;
    e_load  = fr && m_t == 1;
    e_en    = (fr && m_t <= W + 1) || m_phase == 2;
    e_sclr  = (m_phase == 2);
    e_busy  = e_en;
    e_done  = fr && m_t == W + 2;
    e_cnt   = 4'd0;
    if (fr && m_t >= 2 && m_t <= W + 1) e_cnt = 4'(m_t - 2);
    else if (fr && m_t == W + 2)        e_cnt = 4'(W);
    expv = {e_ready, e_load, e_en, e_sclr, e_busy, e_done, 1'b0, e_cnt, m_word};
  end
  assign obs = {in_ready, sr_load, sr_enable, sr_sclr, busy, done, sr_shiftin, bit_cnt, sr_data};

  task automatic test_reset();
    sclr = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_tests++;
      if (obs !== expv || in_ready !== 1'b0 || sr_load !== 1'b0 || sr_enable !== 1'b0 ||
          sr_sclr !== 1'b0 || sr_data !== 8'h00) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %b want %b", i, obs, expv);
      end
    end
    in_valid = 1'b0; sclr = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int k, ndone, dcyc;
    ndone = 0; dcyc = 0;
    in_valid = 1'b1; in_data = 8'hA5;
    k = cyc + 1;
    @(negedge clock);
    n_tests++;
    if (obs !== expv || sr_load !== 1'b1 || sr_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_load: got %b want %b", obs, expv);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_data = 8'($urandom);
      @(negedge clock);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL single_cyc%0d: got %b want %b", i, obs, expv);
      end
      if (done === 1'b1) begin ndone++; dcyc = cyc; end
    end
    n_tests++;
    // Output seen after edge e belongs to cycle e+1.
    if (ndone != 1 || (dcyc + 1) - k != W + 2) begin
      n_fail++;
      $display("FAIL single_done: pulses %0d at +%0d, want 1 at +%0d", ndone, dcyc + 1 - k, W + 2);
    end
  endtask

  task automatic test_abort(input int at_cnt);
    bit found, seen_done;
    found = 0; seen_done = 0;
    in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busy && !sr_load && !sr_sclr && bit_cnt == 4'(at_cnt)) found = 1;
      else @(negedge clock);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort%0d_reach: bit_cnt never reached %0d (got %0d)", at_cnt, at_cnt, bit_cnt);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    n_tests++;
    if (obs !== expv || sr_sclr !== 1'b1 || bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL abort%0d_flush: got %b want %b", at_cnt, obs, expv);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1;
      n_tests++;
      if (obs !== expv || (i == 0 && in_ready !== 1'b1)) begin
        n_fail++;
        $display("FAIL abort%0d_after%0d: got %b want %b", at_cnt, i, obs, expv);
      end
    end
    n_tests++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL abort%0d_nodone: done got 1 want 0", at_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int loads, l0, l1;
    loads = 0; l0 = 0; l1 = 0;
    in_valid = 1'b1; in_data = 8'h3C;
    for (int i = 0; i < 40 && loads < 2; i++) begin
      @(negedge clock);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL b2b_cyc%0d: got %b want %b", i, obs, expv);
      end
      if (sr_load === 1'b1) begin
        loads++;
        if (loads == 1) begin
          l0 = cyc;
          n_tests++;
          if (sr_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL b2b_word0: sr_data got %h want 3c", sr_data);
          end
          in_data = 8'hC3;
        end else begin
          l1 = cyc;
          n_tests++;
          if (sr_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL b2b_word1: sr_data got %h want c3", sr_data);
          end
          in_valid = 1'b0;
        end
      end
    end
    n_tests++;
    if (loads != 2 || l1 - l0 != (B2B ? W + 2 : W + 3)) begin
      n_fail++;
      $display("FAIL b2b_spacing: loads %0d gap %0d want 2 gap %0d", loads, l1 - l0,
               B2B ? W + 2 : W + 3);
    end
    for (int i = 0; i < 12; i++) begin
      in_data = 8'($urandom);
      @(negedge clock);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL b2b_tail%0d: got %b want %b", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit found, seen_done;
    found = 0; seen_done = 0;
    in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (busy && bit_cnt == 4'd5) found = 1;
      else @(negedge clock);
    end
    sclr = 1'b1;
    @(negedge clock);
    sclr = 1'b0;
    #1;
    n_tests++;
    if (!found || obs !== expv || sr_sclr !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: found %0d got %b want %b", found, obs, expv);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done === 1'b1) seen_done = 1;
    end
    n_tests++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL rst_mid_nodone: done got 1 want 0");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
      abort    = ($urandom_range(0, 15) == 0);
      sclr     = ($urandom_range(0, 63) == 0);
      @(negedge clock);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got %b want %b", i, obs, expv);
      end
    end
    in_valid = 1'b0; abort = 1'b0; sclr = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_single();
    test_abort(3);
    test_abort(7);
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
